// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one data memory between the cpu port (r0) and the loader/DMA port (r1)
// A request is granted only once its owner state is reached; a burst is cut short when the other side waits.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_in
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW:0] MAXB = MAX_BURST[CW:0];

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q, state_d, other_state;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW:0]     run;
  logic            last_q, last_d;
  logic            rvalid0_q, rvalid1_q;
  logic            own_req, oth_req, own_is_r1;

  assign own_is_r1   = (state_q == OWN1);
  assign own_req     = own_is_r1 ? req1 : req0;
  assign oth_req     = own_is_r1 ? req0 : req1;
  assign other_state = own_is_r1 ? OWN0 : OWN1;

  assign gnt0   = (state_q == OWN0) & req0 & ~rst;
  assign gnt1   = (state_q == OWN1) & req1 & ~rst;
  assign mem_we = (gnt0 & we0) | (gnt1 & we1);

  // A reset in the cycle after a read grant suppresses that read's rvalid.
  assign rvalid0 = rvalid0_q & ~rst;
  assign rvalid1 = rvalid1_q & ~rst;
  assign rdata   = mem_in;

  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    case (state_q)
      OWN0: begin
        mem_addr = addr0;
        mem_data = wdata0;
      end
      OWN1: begin
        mem_addr = addr1;
        mem_data = wdata1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    run     = {1'b0, cnt_q} + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (own_req) begin
          // >= rather than == so a saturated solo burst still yields promptly.
          if (oth_req && run >= MAXB) begin
            state_d = other_state;
            cnt_d   = '0;
            last_d  = own_is_r1;
          end else if (run <= MAXB) begin
            cnt_d = run[CW-1:0];
          end
        end else begin
          state_d = oth_req ? other_state : IDLE;
          cnt_d   = '0;
          last_d  = own_is_r1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter against a cycle-level behavioural model
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_in;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_in(mem_in)
  );

  // Memory: registered read, read data one cycle after the address.
  logic [DW-1:0] mem     [0:63];
  logic [DW-1:0] ref_mem [0:63];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_in <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: who owns the memory, how long they have held it, who went last.
  int            m_owner = -1;
  int            m_run   = 0;
  int            m_last  = 1;
  bit            m_rv0, m_rv1;
  logic [DW-1:0] m_rd0, m_rd1;

  logic          s_gnt0, s_gnt1, s_rv0, s_rv1, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_rdata, s_data;

  task automatic step();
    int g;
    bit r[2];
    bit exp_we;
    @(negedge clk);
    r[0] = req0;
    r[1] = req1;
    g = -1;
    if (!rst && m_owner >= 0 && r[m_owner]) g = m_owner;
    exp_we = (g == 0) ? we0 : (g == 1) ? we1 : 1'b0;
    check("gnt0", gnt0, g == 0);
    check("gnt1", gnt1, g == 1);
    check("mem_we", mem_we, exp_we);
    if (g >= 0) check("mem_addr", mem_addr, (g == 0) ? addr0 : addr1);
    if (exp_we) check("mem_data", mem_data, (g == 0) ? wdata0 : wdata1);
    if (!rst && m_owner < 0) begin
      check("idle_addr", mem_addr, 0);
      check("idle_data", mem_data, 0);
    end
    check("rvalid0", rvalid0, m_rv0 && !rst);
    check("rvalid1", rvalid1, m_rv1 && !rst);
    if (m_rv0 && !rst) check("rdata0", rdata, m_rd0);
    if (m_rv1 && !rst) check("rdata1", rdata, m_rd1);
    s_gnt0 = gnt0; s_gnt1 = gnt1; s_rv0 = rvalid0; s_rv1 = rvalid1;
    s_rdata = rdata; s_we = mem_we; s_addr = mem_addr; s_data = mem_data;

    m_rv0 = (g == 0) && !we0;
    m_rv1 = (g == 1) && !we1;
    m_rd0 = ref_mem[addr0];
    m_rd1 = ref_mem[addr1];
    if (g == 0 && we0) ref_mem[addr0] = wdata0;
    if (g == 1 && we1) ref_mem[addr1] = wdata1;
    if (rst) begin
      m_owner = -1; m_run = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0;
    end else if (m_owner < 0) begin
      m_run = 0;
      if (r[0] && r[1]) m_owner = 1 - m_last;
      else if (r[0])    m_owner = 0;
      else if (r[1])    m_owner = 1;
    end else if (g == m_owner) begin
      m_run = m_run + 1;
      if (r[1 - m_owner] && m_run >= MB) begin
        m_last = m_owner; m_owner = 1 - m_owner; m_run = 0;
      end else if (m_run > MB) m_run = MB;
    end else begin
      m_last = m_owner;
      m_owner = r[1 - m_owner] ? 1 - m_owner : -1;
      m_run = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] pat;
    bit          busy;
    int          ng1;
    for (int i = 0; i < 64; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[5] = 16'hBEEF; ref_mem[5] = 16'hBEEF;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; we0 = 1'b0; we1 = 1'b0;

    // Reset held with both requesting, then r0 wins first.
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    step();
    step();
    check("t1_gnt_in_rst", {s_gnt0, s_gnt1, s_we, s_rv0}, 0);
    rst = 1'b0;
    step();
    check("t1_arb_cycle", {s_gnt0, s_gnt1}, 0);
    step();
    check("t1_first_gnt", {s_gnt0, s_gnt1}, 2'b10);
    req0 = 1'b0;
    step();
    step();
    req1 = 1'b0;
    step();

    // Single read.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h05;
    step();
    step();
    check("t2_gnt0", s_gnt0, 1);
    req0 = 1'b0;
    step();
    check("t2_rvalid0", s_rv0, 1);
    check("t2_rdata", s_rdata, 16'hBEEF);

    // Write via r1, read back via r0.
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'h3F; wdata1 = 16'h1234;
    step();
    step();
    check("t3_write", {s_we, s_addr, s_data}, {1'b1, 6'h3F, 16'h1234});
    req1 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h3F;
    step();
    step();
    req0 = 1'b0;
    step();
    check("t3_readback", {s_rv0, s_rdata}, {1'b1, 16'h1234});

    // Contention: bursts of MAX_BURST, no bubble between owners.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 6'h01; addr1 = 6'h02;
    step();
    pat = '0; busy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      pat = {pat[10:0], s_gnt1};
      busy &= s_gnt0 | s_gnt1;
    end
    check("t4_pattern", pat, 12'b000011110000);
    check("t4_no_bubble", busy, 1);

    // Release after two grants: r1 then gets a fresh full burst.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    step();
    step();
    step();
    req0 = 1'b0;
    step();
    check("t5_release", s_gnt0, 0);
    req0 = 1'b1;
    ng1 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      ng1 += int'(s_gnt1);
    end
    check("t5_burst1", ng1, 4);
    check("t5_back_to_0", s_gnt0, 1);
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Reset in the cycle after a read grant.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h07;
    step();
    step();
    check("t6_gnt0", s_gnt0, 1);
    req0 = 1'b0; rst = 1'b1;
    step();
    check("t6_rvalid_rst", s_rv0, 0);
    rst = 1'b0; req1 = 1'b1; we1 = 1'b0;
    step();
    check("t6_idle", {s_gnt0, s_gnt1, s_rv0}, 0);
    step();
    req1 = 1'b0;
    step();

    // Randomized traffic; each requester holds its request until granted.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!req0 || s_gnt0) begin
        req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, 7)); wdata0 = DW'($urandom);
      end
      if (!req1 || s_gnt1) begin
        req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, 7)); wdata1 = DW'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
